// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver, one-cycle valid/data pulse per good byte.
// Ports: clk, rst_n (async low), rx (raw line) -> axiov, axiod[7:0],
//        frame_err (stop bit low), busy (not IDLE).
// Option: define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       axiov,
    output logic [7:0] axiod,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      idx, idx_d;
    logic [7:0]      sh, sh_d;
    logic [7:0]      axiod_d;
    logic            axiov_d;
    logic            ferr_d;
    logic            rx_q1, rx_s;
    logic            bit_val;

    // Both flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist holds rx_s from the two previous counts, so the vote
    // covers sample-2, sample-1 and the sample count itself.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_val = (hist[1] & hist[0]) |
                     (hist[1] & rx_s) |
                     (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        sh_d    = sh;
        axiod_d = axiod;
        axiov_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    if (!bit_val) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    // LSB arrives first: shift right, new bit at MSB.
                    sh_d  = {bit_val, sh[7:1]};
                    cnt_d = '0;
                    idx_d = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        axiod_d = sh;
                        axiov_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // A held-low line must not be re-read as new frames.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            axiod     <= '0;
            axiov     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            sh        <= sh_d;
            axiod     <= axiod_d;
            axiov     <= axiov_d;
            frame_err <= ferr_d;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at BAUD_DIV = 16.
// Frames, back-to-back, framing error, glitch, reset abort, voting.
module tb_uart_rx;

    localparam int B = 16;
    // rx -> rx_s is 2 cycles, rx_s low -> axiov is B/2 + 9*B + 1.
    localparam int LAT = 2 + B / 2 + 9 * B + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       axiov;
    logic [7:0] axiod;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_ferr = 0;
    int n_both = 0;
    int v_cyc[$];
    logic [7:0] v_dat[$];

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .axiov(axiov),
        .axiod(axiod),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (axiov) begin
                v_cyc.push_back(cyc);
                v_dat.push_back(axiod);
            end
            if (frame_err) n_ferr++;
            if (axiov && frame_err) n_both++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit glitch, input int abort_bit,
                              output int t_start);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        t_start = cyc;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < B; j++) begin
                if (b == abort_bit && j == 8) return;
                rx = f[b] ^ (glitch && b >= 1 && b <= 8 && j == 8);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        idle(3);
        rst_n = 1'b1;
        idle(3);
        n_vec++;
        if (axiov !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_axiov: got %b want 0", axiov);
        end
        n_vec++;
        if (axiod !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_axiod: got %h want 00", axiod);
        end
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ferr: got %b want 0", frame_err);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        int t;
        v_cyc.delete();
        v_dat.delete();
        send_frame(8'hA5, 1'b1, 1'b0, -1, t);
        idle(20);
        n_vec++;
        if (v_dat.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d want 1", v_dat.size());
        end
        if (v_dat.size() >= 1) begin
            n_vec++;
            if (v_dat[0] !== 8'hA5) begin
                n_bad++;
                $display("FAIL single_data: got %h want a5", v_dat[0]);
            end
            n_vec++;
            if (v_cyc[0] != t + LAT) begin
                n_bad++;
                $display("FAIL single_latency: got %0d want %0d",
                         v_cyc[0] - t - 2, LAT - 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        int fe0;
        logic [7:0] exp [3];
        exp[0] = 8'h00;
        exp[1] = 8'hFF;
        exp[2] = 8'h3C;
        fe0 = n_ferr;
        v_cyc.delete();
        v_dat.delete();
        send_frame(exp[0], 1'b1, 1'b0, -1, t0);
        send_frame(exp[1], 1'b1, 1'b0, -1, t1);
        send_frame(exp[2], 1'b1, 1'b0, -1, t2);
        idle(30);
        n_vec++;
        if (v_dat.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 3", v_dat.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (v_dat.size() > i) begin
                n_vec++;
                if (v_dat[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL b2b_data%0d: got %h want %h",
                             i, v_dat[i], exp[i]);
                end
            end
        end
        if (v_cyc.size() >= 3) begin
            n_vec++;
            if (v_cyc[2] != t2 + LAT) begin
                n_bad++;
                $display("FAIL b2b_latency: got %0d want %0d",
                         v_cyc[2] - t2, LAT);
            end
        end
        n_vec++;
        if (n_ferr != fe0) begin
            n_bad++;
            $display("FAIL b2b_ferr: got %0d want 0", n_ferr - fe0);
        end
    endtask

    task automatic test_frame_err();
        int t;
        int fe0;
        bit busy_dropped;
        fe0 = n_ferr;
        busy_dropped = 1'b0;
        v_cyc.delete();
        v_dat.delete();
        send_frame(8'h55, 1'b0, 1'b0, -1, t);
        repeat (40 * B) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_dropped = 1'b1;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (busy_dropped) begin
            n_bad++;
            $display("FAIL ferr_busy_hold: got 0 want 1");
        end
        rx = 1'b1;
        idle(4);
        n_vec++;
        if (n_ferr - fe0 != 1) begin
            n_bad++;
            $display("FAIL ferr_count: got %0d want 1", n_ferr - fe0);
        end
        n_vec++;
        if (v_dat.size() != 0) begin
            n_bad++;
            $display("FAIL ferr_axiov: got %0d want 0", v_dat.size());
        end
        n_vec++;
        if (axiod !== 8'h3C) begin
            n_bad++;
            $display("FAIL ferr_axiod: got %h want 3c", axiod);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ferr_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_glitch();
        int t;
        int fe0;
        fe0 = n_ferr;
        v_cyc.delete();
        v_dat.delete();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy: got %b want 1", busy);
        end
        idle(10);
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_idle: got %b want 0", busy);
        end
        n_vec++;
        if (v_dat.size() != 0 || n_ferr != fe0) begin
            n_bad++;
            $display("FAIL glitch_out: got %0d/%0d want 0/0",
                     v_dat.size(), n_ferr - fe0);
        end
        send_frame(8'h81, 1'b1, 1'b0, -1, t);
        idle(20);
        n_vec++;
        if (v_dat.size() != 1 || v_dat[0] !== 8'h81) begin
            n_bad++;
            $display("FAIL glitch_next: got n=%0d %h want 1 81",
                     v_dat.size(), axiod);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int fe0;
        v_cyc.delete();
        v_dat.delete();
        send_frame(8'h7E, 1'b1, 1'b0, 5, t);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_busy_pre: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (axiov !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_flags: got %b%b%b want 000",
                     axiov, frame_err, busy);
        end
        n_vec++;
        if (axiod !== 8'h00) begin
            n_bad++;
            $display("FAIL rmid_axiod: got %h want 00", axiod);
        end
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        fe0 = n_ferr;
        idle(200);
        n_vec++;
        if (v_dat.size() != 0 || n_ferr != fe0) begin
            n_bad++;
            $display("FAIL rmid_pulse: got %0d/%0d want 0/0",
                     v_dat.size(), n_ferr - fe0);
        end
        send_frame(8'h7E, 1'b1, 1'b0, -1, t);
        idle(20);
        n_vec++;
        if (v_dat.size() != 1 || axiod !== 8'h7E) begin
            n_bad++;
            $display("FAIL rmid_next: got n=%0d %h want 1 7e",
                     v_dat.size(), axiod);
        end
    endtask

    task automatic test_majority();
        int t;
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
        want = 8'hC3;
`else
        want = 8'h3C;
`endif
        v_cyc.delete();
        v_dat.delete();
        send_frame(8'hC3, 1'b1, 1'b1, -1, t);
        idle(20);
        n_vec++;
        if (v_dat.size() != 1 || axiod !== want) begin
            n_bad++;
            $display("FAIL majority: got n=%0d %h want 1 %h",
                     v_dat.size(), axiod, want);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_majority();
        n_vec++;
        if (n_both != 0) begin
            n_bad++;
            $display("FAIL overlap: got %0d want 0", n_both);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the PC link: samples the serial `rx` line and delivers each received 8-N-1 byte as a one-cycle valid/data pulse to the command and decoding logic downstream. It is the receive counterpart of the board's UART transmitter and runs in the same 50 MHz clock domain. Start bits are re-validated at mid-bit and stop bits are checked. Framing errors are reported, never delivered as data.

## Interface
- `BAUD_DIV`, 434, clock cycles per bit (50 MHz / 115200); must be ≥ 8.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `axiov`  out  1  one-cycle pulse: `axiod` holds a good byte.
- `axiod`  out  8  received byte, LSB first on the wire; held until the next good byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`; all decisions use `rx_s`.
- One bit counter `cnt` (width `$clog2(BAUD_DIV)`), one bit index (0..7) and one 8-bit shift register.
- States and transitions:
  - **IDLE**: go to START with `cnt` = 0 when `rx_s` = 0.
  - **START**: `cnt` counts to `BAUD_DIV/2 - 1` (integer division). At that count:
    - `rx_s` = 0: go to DATA, `cnt` = 0, index = 0.
    - `rx_s` = 1: treat as a glitch and return to IDLE with no output.
  - **DATA**: `cnt` counts 0..`BAUD_DIV-1`. At `BAUD_DIV-1`:
    - shift the sampled bit in at the MSB with a right shift, so the first bit ends up as bit 0;
    - `cnt` = 0;
    - after index 7, go to STOP.
  - **STOP**: at `cnt` = `BAUD_DIV-1`, sample the line.
    - Sampled 1: `axiod` ← shift register, pulse `axiov`, go to IDLE.
    - Sampled 0: pulse `frame_err`, leave `axiod` unchanged, go to BREAK.
  - **BREAK**: wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- There is no backpressure. The consumer must accept `axiov` on the cycle it is pulsed.
- Reset values:
  - state IDLE;
  - `cnt`, index and shift register all 0;
  - `axiov` = 0, `axiod` = 0x00, `frame_err` = 0, `busy` = 0;
  - both synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No `axiov` or `frame_err` follows the frame that was in progress.

## Timing
- `rx` → `rx_s`: 2 cycles.
- `axiov` or `frame_err` is registered. It asserts one cycle after the STOP sample cycle.
- From the first `rx_s` = 0 cycle to `axiov` high: `BAUD_DIV/2 + 9*BAUD_DIV + 1` cycles.
  - `BAUD_DIV` = 16: 153 cycles.
  - `BAUD_DIV` = 434: 4124 cycles.
- `axiov` and `frame_err` are each exactly one cycle wide and are never high together.
- Back-to-back frames:
  - The pulse for a frame asserts while the state is already IDLE.
  - A start bit that begins half a bit after the stop sample is detected.
  - No frames are lost at the full line rate.
- `busy` goes high the cycle after `rx_s` falls in IDLE. It goes low on the cycle the state returns to IDLE.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - **Defined**: every bit decision (start check, data bits, stop bit) is the 2-of-3 majority of `rx_s` at the three counts ending at the sample point, i.e. sample−2, sample−1 and sample. This needs a 2-bit sample history. Latency and sample-point counts are unchanged.
  - **Not defined**: the single `rx_s` value at the sample count is used. The history registers are not built.

## Test plan
- `BAUD_DIV` = 16, send 0xA5 framed 8-N-1.
  - Required: `axiov` pulses once, `axiod` = 0xA5, exactly 153 cycles after the first `rx_s` low.
- Send 0x00, 0xFF and 0x3C back-to-back with no idle gap.
  - Required: three `axiov` pulses in order with those values; `frame_err` never asserts.
- Send 0x55 with the stop bit driven low, then hold `rx` low for 40 bit times, then high.
  - Required: one `frame_err` pulse, no `axiov`, `axiod` keeps its prior value, `busy` stays high until `rx` returns high.
- Drive a 3-cycle low glitch on an idle line.
  - Required: the block returns to IDLE at the start check with no output; the next 0x81 frame is received correctly.
- Assert `rst_n` low during data bit 4 of a frame, then release it.
  - Required: all outputs go to their reset values immediately; no pulse for the aborted frame; the next 0x7E frame is received correctly.
- With `UART_RX_MAJORITY_EN` defined, inject a 1-cycle inverted glitch exactly on the sample count of every data bit of 0xC3.
  - Required: `axiod` = 0xC3.
  - Without the macro, the same stimulus gives `axiod` = 0x3C.
